dsp_cmd_encoder: RTL and testbench



---
 rtl/dsp_cmd_encoder.sv | 178 +++++++++++++++++
 tb/tb_dsp_cmd_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_cmd_encoder.sv
// dsp_cmd_encoder: serialises structured host commands into the engine's
// command byte stream, pacing each byte against the engine's SPI FIFO level.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready            : one command per handshake
//   cmd_kind/opcode/block/reg/data : command fields, latched at accept
//   command_out, command_out_ready : byte to engine plus one-cycle write strobe
//   fifo_count                     : engine FIFO fill level (throttles bytes)
//   invalid_command, err_clear     : engine error input and its clear
//   err_sticky                     : latched engine error
//   busy                           : frame in progress
//   frames_sent, bytes_sent        : statistics, present only with CMD_ENC_STATS_EN
//
// Optional feature macro: CMD_ENC_STATS_EN
module dsp_cmd_encoder #(
  parameter int unsigned n_blocks        = 255,
  parameter int unsigned data_width      = 16,
  parameter int unsigned spi_fifo_length = 32,
  parameter int unsigned fifo_headroom   = 2,
  parameter int unsigned byte_gap        = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_kind,
  input  logic [7:0]                         cmd_opcode,
  input  logic [$clog2(n_blocks)-1:0]        cmd_block,
  input  logic [3:0]                         cmd_reg,
  input  logic [data_width-1:0]              cmd_data,
  output logic [7:0]                         command_out,
  output logic                               command_out_ready,
  input  logic [$clog2(spi_fifo_length):0]   fifo_count,
  input  logic                               invalid_command,
  output logic                               err_sticky,
  input  logic                               err_clear,
`ifdef CMD_ENC_STATS_EN
  output logic [31:0]                        frames_sent,
  output logic [31:0]                        bytes_sent,
`endif
  output logic                               busy
);

  localparam int unsigned DATA_BYTES = data_width / 8;
  localparam int unsigned MAX_LEN    = 3 + DATA_BYTES;
  localparam int unsigned FRAME_W    = 8 * MAX_LEN;
  localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W      = $clog2(spi_fifo_length) + 1;
  localparam int unsigned GAP_W      = (byte_gap > 1) ? $clog2(byte_gap) : 1;
  localparam int unsigned THRESH     = spi_fifo_length - fifo_headroom;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state;
  logic [FRAME_W-1:0] frame;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   idx;
  logic [GAP_W-1:0]   gap_cnt;

  logic [FRAME_W-1:0] frame_c;
  logic [LEN_W-1:0]   len_c;
  logic               issue_c;
  logic               last_c;

  // Assemble the frame MSB-first so bytes leave from the top of the register.
  always_comb begin
    frame_c = '0;
    len_c   = '0;
    frame_c[FRAME_W-1 -: 8] = cmd_opcode;
    case (cmd_kind)
      2'd0: len_c = LEN_W'(1);
      2'd1: begin
        frame_c[FRAME_W-9 -: 8] = 8'(cmd_block);
        len_c = LEN_W'(2);
      end
      2'd2: begin
        frame_c[FRAME_W-9  -: 8] = 8'(cmd_block);
        frame_c[FRAME_W-17 -: 8] = 8'(cmd_reg);
        frame_c[data_width-1:0]  = cmd_data;
        len_c = LEN_W'(3 + DATA_BYTES);
      end
      default: begin
        frame_c[FRAME_W-9 -: data_width] = cmd_data;
        len_c = LEN_W'(1 + DATA_BYTES);
      end
    endcase
  end

  // A byte goes out only while the engine FIFO keeps the required headroom.
  assign issue_c = (state == SEND) && (fifo_count < CNT_W'(THRESH));
  assign last_c  = (idx == len - LEN_W'(1));

  // Frame sequencer: IDLE accepts, SEND emits one strobed byte, GAP spaces bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      frame             <= '0;
      len               <= '0;
      idx               <= '0;
      gap_cnt           <= '0;
      command_out       <= '0;
      command_out_ready <= 1'b0;
      cmd_ready         <= 1'b1;
      busy              <= 1'b0;
    end else begin
      command_out_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            frame     <= frame_c;
            len       <= len_c;
            idx       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (issue_c) begin
            command_out       <= frame[FRAME_W-1 -: 8];
            command_out_ready <= 1'b1;
            frame             <= frame << 8;
            gap_cnt           <= '0;
            state             <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(byte_gap - 1)) begin
            if (last_c) begin
              idx       <= '0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              idx   <= idx + LEN_W'(1);
              state <= SEND;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Sticky engine error; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sticky <= 1'b0;
    end else if (invalid_command) begin
      err_sticky <= 1'b1;
    end else if (err_clear) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef CMD_ENC_STATS_EN
  // Traffic counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_sent <= '0;
      bytes_sent  <= '0;
    end else if (issue_c) begin
      bytes_sent <= bytes_sent + 32'd1;
      if (last_c) begin
        frames_sent <= frames_sent + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dsp_cmd_encoder.sv
// Bench for dsp_cmd_encoder: table of single-command frames plus directed
// sequences for back-to-back, FIFO throttling, mid-frame reset and error flag.
module tb_dsp_cmd_encoder;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_kind;
  logic [7:0]  cmd_opcode;
  logic [7:0]  cmd_block;
  logic [3:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic [7:0]  command_out;
  logic        command_out_ready;
  logic [5:0]  fifo_count;
  logic        invalid_command;
  logic        err_sticky;
  logic        err_clear;
  logic        busy;
`ifdef CMD_ENC_STATS_EN
  logic [31:0] frames_sent;
  logic [31:0] bytes_sent;
`endif

  dsp_cmd_encoder dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_kind          (cmd_kind),
    .cmd_opcode        (cmd_opcode),
    .cmd_block         (cmd_block),
    .cmd_reg           (cmd_reg),
    .cmd_data          (cmd_data),
    .command_out       (command_out),
    .command_out_ready (command_out_ready),
    .fifo_count        (fifo_count),
    .invalid_command   (invalid_command),
    .err_sticky        (err_sticky),
    .err_clear         (err_clear),
`ifdef CMD_ENC_STATS_EN
    .frames_sent       (frames_sent),
    .bytes_sent        (bytes_sent),
`endif
    .busy              (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  op;
    logic [7:0]  blk;
    logic [3:0]  rg;
    logic [15:0] data;
    logic [5:0]  fifo;
    logic [3:0]  len;
    logic [39:0] exp_bytes;
  } vec_t;

  vec_t vecs [7];

  int tests;
  int fails;

  logic [7:0] got [16];
  int         got_cyc [16];
  int         got_n;
  int         busy_cyc;
  logic       timed_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record strobed bytes until the encoder returns to ready.
  task automatic collect();
    int n;
    n        = 0;
    got_n    = 0;
    busy_cyc = 0;
    while (!cmd_ready && n < 400) begin
      if (busy) busy_cyc++;
      if (command_out_ready) begin
        if (got_n < 16) begin
          got[got_n]     = command_out;
          got_cyc[got_n] = n;
        end
        got_n++;
      end
      tick();
      n++;
    end
    timed_out = !cmd_ready;
  endtask

  task automatic issue(input logic [1:0] k, input logic [7:0] op, input logic [7:0] blk,
                       input logic [3:0] rg, input logic [15:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_kind   = k;
    cmd_opcode = op;
    cmd_block  = blk;
    cmd_reg    = rg;
    cmd_data   = d;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] k, input logic [7:0] op, input logic [7:0] blk,
                         input logic [3:0] rg, input logic [15:0] d);
    issue(k, op, blk, rg, d);
    collect();
    chk("frame_timeout", 32'(timed_out), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind = '0;
    cmd_opcode = '0;
    cmd_block = '0;
    cmd_reg = '0;
    cmd_data = '0;
    fifo_count = '0;
    invalid_command = 1'b0;
    err_clear = 1'b0;

    //            kind  op     blk    rg     data      fifo   len   expected bytes (MSB first)
    vecs[0] = '{2'd2, 8'h05, 8'h03, 4'h7, 16'hABCD, 6'd0,  4'd5, 40'h05_03_07_AB_CD};
    vecs[1] = '{2'd0, 8'h10, 8'h55, 4'h3, 16'hBEEF, 6'd0,  4'd1, 40'h10_00_00_00_00};
    vecs[2] = '{2'd3, 8'h21, 8'h00, 4'h0, 16'h1234, 6'd0,  4'd3, 40'h21_12_34_00_00};
    vecs[3] = '{2'd1, 8'h02, 8'h09, 4'hA, 16'h5555, 6'd0,  4'd2, 40'h02_09_00_00_00};
    vecs[4] = '{2'd2, 8'hFF, 8'h00, 4'hF, 16'h0000, 6'd29, 4'd5, 40'hFF_00_0F_00_00};
    vecs[5] = '{2'd3, 8'h00, 8'h77, 4'h1, 16'hFFFF, 6'd29, 4'd3, 40'h00_FF_FF_00_00};
    vecs[6] = '{2'd1, 8'hA5, 8'hFE, 4'h0, 16'h0001, 6'd10, 4'd2, 40'hA5_FE_00_00_00};

    // Reset state
    #12;
    chk("rst_command_out", 32'(command_out), 32'h0);
    chk("rst_strobe", 32'(command_out_ready), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef CMD_ENC_STATS_EN
    chk("rst_frames_sent", frames_sent, 32'd0);
    chk("rst_bytes_sent", bytes_sent, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Table-driven single frames
    for (int v = 0; v < 7; v++) begin
      fifo_count = vecs[v].fifo;
      run_cmd(vecs[v].kind, vecs[v].op, vecs[v].blk, vecs[v].rg, vecs[v].data);
      chk($sformatf("v%0d_byte_count", v), 32'(got_n), 32'(vecs[v].len));
      chk($sformatf("v%0d_busy_cycles", v), 32'(busy_cyc), 32'(2 * int'(vecs[v].len)));
      if (got_n > 0)
        chk($sformatf("v%0d_first_latency", v), 32'(got_cyc[0] >= 1), 32'd1);
      for (int i = 0; i < int'(vecs[v].len) && i < got_n; i++) begin
        chk($sformatf("v%0d_byte%0d", v, i), 32'(got[i]), 32'(vecs[v].exp_bytes[39 - 8*i -: 8]));
        if (i > 0)
          chk($sformatf("v%0d_spacing%0d", v, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd2);
      end
      chk($sformatf("v%0d_idle_ready", v), 32'(cmd_ready && !busy), 32'd1);
    end
    fifo_count = '0;

    // Back-to-back: kind 0 then kind 3 held valid
    begin
      int acc;
      int sec_cyc;
      logic [31:0] exp_b2b;
      acc = 0;
      sec_cyc = -1;
      got_n = 0;
      exp_b2b = 32'h10_21_12_34;
      cmd_valid = 1'b1;
      cmd_kind = 2'd0;
      cmd_opcode = 8'h10;
      for (int c = 0; c < 40; c++) begin
        logic a;
        a = cmd_valid && cmd_ready;
        tick();
        if (a) begin
          acc++;
          if (acc == 1) begin
            cmd_kind = 2'd3;
            cmd_opcode = 8'h21;
            cmd_data = 16'h1234;
          end else begin
            cmd_valid = 1'b0;
            sec_cyc = c;
          end
        end
        if (command_out_ready) begin
          if (got_n < 16) begin
            got[got_n] = command_out;
            got_cyc[got_n] = c;
          end
          got_n++;
        end
      end
      cmd_valid = 1'b0;
      chk("b2b_accepts", 32'(acc), 32'd2);
      chk("b2b_byte_count", 32'(got_n), 32'd4);
      for (int i = 0; i < 4 && i < got_n; i++)
        chk($sformatf("b2b_byte%0d", i), 32'(got[i]), 32'(exp_b2b[31 - 8*i -: 8]));
      if (got_n >= 4) begin
        chk("b2b_second_after_first", 32'(sec_cyc > got_cyc[0]), 32'd1);
        chk("b2b_frame_spacing", 32'(got_cyc[1] - got_cyc[0] >= 2), 32'd1);
        chk("b2b_spacing2", 32'(got_cyc[2] - got_cyc[1]), 32'd2);
        chk("b2b_spacing3", 32'(got_cyc[3] - got_cyc[2]), 32'd2);
      end
    end

    // FIFO at threshold: frame stalls, then drains in order
    begin
      int strobes;
      strobes = 0;
      fifo_count = 6'd30;
      issue(2'd1, 8'h02, 8'h09, 4'h0, 16'h0);
      for (int c = 0; c < 20; c++) begin
        if (command_out_ready) strobes++;
        tick();
      end
      chk("throttle_no_strobe", 32'(strobes), 32'd0);
      chk("throttle_busy", 32'(busy), 32'd1);
      chk("throttle_not_ready", 32'(cmd_ready), 32'd0);
      fifo_count = 6'd5;
      collect();
      chk("throttle_timeout", 32'(timed_out), 32'd0);
      chk("throttle_count", 32'(got_n), 32'd2);
      if (got_n >= 2) begin
        chk("throttle_byte0", 32'(got[0]), 32'h02);
        chk("throttle_byte1", 32'(got[1]), 32'h09);
      end
      fifo_count = '0;
    end

    // Reset after second byte of a kind 2 frame
    begin
      int seen;
      seen = 0;
      issue(2'd2, 8'h05, 8'h03, 4'h7, 16'hABCD);
      for (int c = 0; c < 20 && seen < 2; c++) begin
        tick();
        if (command_out_ready) seen++;
      end
      chk("midrst_reached_byte2", 32'(seen), 32'd2);
      reset = 1'b0;
      #1;
      chk("midrst_strobe_drop", 32'(command_out_ready), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_command_out", 32'(command_out), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      run_cmd(2'd0, 8'h33, 8'h0, 4'h0, 16'h0);
      chk("midrst_new_count", 32'(got_n), 32'd1);
      if (got_n >= 1) chk("midrst_new_byte", 32'(got[0]), 32'h33);
    end

    // Sticky error flag
    chk("err_initial", 32'(err_sticky), 32'd0);
    invalid_command = 1'b1;
    tick();
    invalid_command = 1'b0;
    chk("err_set", 32'(err_sticky), 32'd1);
    invalid_command = 1'b1;
    err_clear = 1'b1;
    tick();
    invalid_command = 1'b0;
    chk("err_set_wins", 32'(err_sticky), 32'd1);
    tick();
    err_clear = 1'b0;
    chk("err_cleared", 32'(err_sticky), 32'd0);
    tick();
    chk("err_stays_clear", 32'(err_sticky), 32'd0);

`ifdef CMD_ENC_STATS_EN
    // Statistics after a fresh reset: kind 2 then kind 1
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_cmd(2'd2, 8'h05, 8'h03, 4'h7, 16'hABCD);
    run_cmd(2'd1, 8'h02, 8'h09, 4'h0, 16'h0);
    chk("stats_frames", frames_sent, 32'd2);
    chk("stats_bytes", bytes_sent, 32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
